gnn_neighbor_aggr: RTL and testbench
====================================

Name: gnn_neighbor_aggr

Overview:
- Graph aggregation stage between layer-1 ReLU outputs (y4..y7_relu_p3) and output-layer inputs (y4..y7_aggr_p3) of the time-multiplexed DNN/GNN compute block.
- Tracks the compute block's 4-cycle schedule with a shadow phase FSM.
- Stores each processed node's ReLU feature vector in a small node-feature memory.
- In the aggregation cycle, returns the current node's features plus the sum of features of its valid adjacent neighbours.

Parameters:
- NUM_NODES, 4, number of node-feature slots. Legal range 2..4; keeps the 4-term sum within 17 bits.
- FEAT_W, 15, ReLU feature width.
- AGGR_W, 17, aggregated output width. Must be ≥ FEAT_W + 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_ready  in  1  same strobe as the compute block's in_ready
- node_id  in  2  current node slot; sampled when in_ready is accepted
- adj_mask  in  NUM_NODES  neighbour bitmap for the current node; sampled with node_id
- clear  in  1  synchronous flush of all slot-valid bits
- y4_relu_p3, y5_relu_p3, y6_relu_p3, y7_relu_p3  in  FEAT_W each, signed  layer-1 ReLU outputs
- y4_aggr_p3, y5_aggr_p3, y6_aggr_p3, y7_aggr_p3  out  AGGR_W each, signed  aggregated features
- aggr_valid  out  1  high in the aggregation cycle
- slots_valid  out  NUM_NODES  per-slot occupancy bits

Behaviour:
- Reset state, applied on the clk edge with rst high:
  - Phase = P_IDLE.
  - Latched node_id, adj_mask and slots_valid = 0.
  - Feature memory contents are don't-care; slots_valid gates every use.
- Reset behaviour of outputs: aggr_valid = 0 and all aggr outputs = 0 from the cycle after the reset edge.
- Phase FSM (mirrors the compute FSM):
  - P_IDLE → P_MUL2 when in_ready = 1; node_id and adj_mask are latched on that edge.
  - P_MUL2 → P_AGGR unconditionally.
  - P_AGGR → P_OUT unconditionally.
  - P_OUT → P_IDLE unconditionally.
  - in_ready outside P_IDLE is ignored, and the latched values do not change.
- Latency: P_AGGR is exactly 2 cycles after the in_ready-accept edge. This is the cycle in which the compute block holds all four ReLU values valid and samples the aggr inputs.
- Output in P_AGGR (combinational from the live ReLU inputs plus registered memory):
  - yK_aggr = sext(yK_relu) + Σ sext(mem[j][K]) over every j that satisfies all of: j ≠ node_id_lat, adj_mask_lat[j] = 1, slots_valid[j] = 1.
  - aggr_valid = 1.
- Self term: always the live ReLU value. adj_mask_lat[node_id_lat] is ignored, and a stale self slot never contributes.
- Outside P_AGGR: all aggr outputs = 0 and aggr_valid = 0.
- Width: ReLU inputs are non-negative. The worst case is 4 × 16383 = 65532, which fits signed 17 bits, so no saturation is needed.
- Memory write, on the edge ending P_AGGR:
  - mem[node_id_lat] ← {y4..y7_relu_p3}.
  - slots_valid[node_id_lat] ← 1.
  - A node_id_lat ≥ NUM_NODES gives no write; aggregation still proceeds.
- Neighbour writes in a run: a neighbour written earlier in the same run is visible to later nodes. Ordering is the host's responsibility.
- clear:
  - When clear = 1, slots_valid ← 0 on the next edge.
  - clear coinciding with the P_AGGR write edge wins: the write is dropped, and slots_valid is all zero afterwards.
  - The aggr output in that P_AGGR cycle still uses the pre-clear memory.
  - clear does not affect the phase FSM.
- rst mid-operation: phase returns to P_IDLE and any pending write is dropped. The compute block must be reset together with this block.
- No back-pressure; the schedule is fixed.

Test Plan:
- Reset then one node: in_ready with node_id=0, adj_mask=4'b1111, relu = {100,200,300,400} in P_AGGR. Required: aggr = {100,200,300,400}, aggr_valid=1 for exactly one cycle 2 cycles after accept, slots_valid=4'b0001 afterwards.
- Neighbour sum:
  - Store node0 = {10,20,30,40} and node1 = {1,2,3,4}.
  - Then node2 with adj_mask=4'b0011 and relu {5,5,5,5}. Required: aggr = {16,27,38,49}.
  - Repeat with adj_mask=4'b0001. Required: aggr = {15,25,35,45}.
- Max width: slots 0,1,2 hold 16383 in every lane; node3 with adj_mask=4'b1111 and relu 16383. Required: aggr = 65532 in every lane, with no sign flip.
- Self-slot ignore and overwrite:
  - Node1 reprocessed with adj_mask=4'b0010 and relu {7,7,7,7}. Required: aggr = {7,7,7,7}.
  - Then mem[1] = {7,7,7,7}.
- clear collision: assert clear in the P_AGGR cycle of node0. Required: output uses the old neighbours, and slots_valid = 0 afterwards. The next node with adj_mask=4'b1111 gets aggr equal to its own relu only.
- Ignored strobe and reset:
  - in_ready pulsed during P_MUL2 with a different node_id. Required: no change to the latched node_id.
  - rst during P_MUL2. Required: aggr_valid never asserts and slots_valid = 0.

Source files
------------

// File: rtl/gnn_neighbor_aggr.sv
// gnn_neighbor_aggr: shadows the compute block's 4-phase schedule and adds stored neighbour features to the live ReLU outputs
module gnn_neighbor_aggr #(
  parameter int NUM_NODES = 4,
  parameter int FEAT_W    = 15,
  parameter int AGGR_W    = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_ready,
  input  logic [1:0]                  node_id,
  input  logic [NUM_NODES-1:0]        adj_mask,
  input  logic                        clear,
  input  logic signed [FEAT_W-1:0]    y4_relu_p3,
  input  logic signed [FEAT_W-1:0]    y5_relu_p3,
  input  logic signed [FEAT_W-1:0]    y6_relu_p3,
  input  logic signed [FEAT_W-1:0]    y7_relu_p3,
  output logic signed [AGGR_W-1:0]    y4_aggr_p3,
  output logic signed [AGGR_W-1:0]    y5_aggr_p3,
  output logic signed [AGGR_W-1:0]    y6_aggr_p3,
  output logic signed [AGGR_W-1:0]    y7_aggr_p3,
  output logic                        aggr_valid,
  output logic [NUM_NODES-1:0]        slots_valid
);
  typedef enum logic [1:0] {P_IDLE, P_MUL2, P_AGGR, P_OUT} phase_t;
  phase_t                     phase;
  phase_t                     phase_nxt;
  logic [1:0]                 node_lat;
  logic [NUM_NODES-1:0]       adj_lat;
  logic [NUM_NODES-1:0]       nbr;
  logic                       wr;
  logic signed [FEAT_W-1:0]   relu [4];
  logic signed [AGGR_W-1:0]   sum [4];
  logic signed [FEAT_W-1:0]   mem [NUM_NODES][4];
  assign relu[0] = y4_relu_p3;
  assign relu[1] = y5_relu_p3;
  assign relu[2] = y6_relu_p3;
  assign relu[3] = y7_relu_p3;
  assign phase_nxt = phase == P_IDLE ? (in_ready ? P_MUL2 : P_IDLE) :
                     phase == P_MUL2 ? P_AGGR :
                     phase == P_AGGR ? P_OUT : P_IDLE;
  // out-of-range node ids still aggregate but never land in memory; clear drops the write
  assign wr = phase == P_AGGR && int'(node_lat) < NUM_NODES && !clear;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= P_IDLE;
      node_lat    <= '0;
      adj_lat     <= '0;
      slots_valid <= '0;
    end else begin
      phase <= phase_nxt;
      if (phase == P_IDLE && in_ready) begin
        node_lat <= node_id;
        adj_lat  <= adj_mask;
      end
      slots_valid <= clear ? '0 : wr ? slots_valid | (NUM_NODES'(1) << node_lat) : slots_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !rst)
      for (int k = 0; k < 4; k++) mem[node_lat][k] <= relu[k];
  end
  // self slot is excluded so the live ReLU value is the only self term
  always_comb begin
    for (int j = 0; j < NUM_NODES; j++)
      nbr[j] = int'(node_lat) != j && adj_lat[j] && slots_valid[j];
    for (int k = 0; k < 4; k++) begin
      sum[k] = AGGR_W'(relu[k]);
      for (int j = 0; j < NUM_NODES; j++)
        sum[k] = nbr[j] ? sum[k] + AGGR_W'(mem[j][k]) : sum[k];
      sum[k] = phase == P_AGGR ? sum[k] : '0;
    end
  end
  assign y4_aggr_p3 = sum[0];
  assign y5_aggr_p3 = sum[1];
  assign y6_aggr_p3 = sum[2];
  assign y7_aggr_p3 = sum[3];
  assign aggr_valid = phase == P_AGGR;
endmodule

// File: tb/tb_gnn_neighbor_aggr.sv
// tb_gnn_neighbor_aggr: table-driven node runs plus hand sequences for strobe-ignore and mid-run reset
module tb_gnn_neighbor_aggr;
  logic clk = 1'b0;
  logic rst, in_ready, clear;
  logic [1:0] node_id;
  logic [3:0] adj_mask;
  logic signed [14:0] y4_relu_p3, y5_relu_p3, y6_relu_p3, y7_relu_p3;
  logic signed [16:0] y4_aggr_p3, y5_aggr_p3, y6_aggr_p3, y7_aggr_p3;
  logic aggr_valid;
  logic [3:0] slots_valid;
  gnn_neighbor_aggr dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .node_id(node_id), .adj_mask(adj_mask),
    .clear(clear), .y4_relu_p3(y4_relu_p3), .y5_relu_p3(y5_relu_p3), .y6_relu_p3(y6_relu_p3),
    .y7_relu_p3(y7_relu_p3), .y4_aggr_p3(y4_aggr_p3), .y5_aggr_p3(y5_aggr_p3),
    .y6_aggr_p3(y6_aggr_p3), .y7_aggr_p3(y7_aggr_p3), .aggr_valid(aggr_valid),
    .slots_valid(slots_valid)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0]  id;
    logic [3:0]  adj;
    logic        clr;
    logic [3:0]  slots;
    logic [14:0] r0, r1, r2, r3;
    logic [16:0] e0, e1, e2, e3;
  } vec_t;
  vec_t vq[$];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [1:0] id, input logic [3:0] adj, input logic clr,
                     input int r0, input int r1, input int r2, input int r3,
                     input int e0, input int e1, input int e2, input int e3,
                     input logic [3:0] slots);
    vec_t v;
    v.id = id; v.adj = adj; v.clr = clr; v.slots = slots;
    v.r0 = 15'(r0); v.r1 = 15'(r1); v.r2 = 15'(r2); v.r3 = 15'(r3);
    v.e0 = 17'(e0); v.e1 = 17'(e1); v.e2 = 17'(e2); v.e3 = 17'(e3);
    vq.push_back(v);
  endtask
  function automatic logic [67:0] aggr_bus();
    return {y4_aggr_p3, y5_aggr_p3, y6_aggr_p3, y7_aggr_p3};
  endfunction
  task automatic run(input vec_t v, input int idx);
    in_ready = 1'b1; node_id = v.id; adj_mask = v.adj;
    @(posedge clk); @(negedge clk);
    in_ready = 1'b0;
    chk($sformatf("v%0d_mul2_valid", idx), 68'(aggr_valid), 68'(0));
    @(posedge clk); @(negedge clk);
    y4_relu_p3 = v.r0; y5_relu_p3 = v.r1; y6_relu_p3 = v.r2; y7_relu_p3 = v.r3;
    clear = v.clr;
    #1;
    chk($sformatf("v%0d_aggr_valid", idx), 68'(aggr_valid), 68'(1));
    chk($sformatf("v%0d_aggr", idx), aggr_bus(), {v.e0, v.e1, v.e2, v.e3});
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    chk($sformatf("v%0d_out_valid", idx), 68'(aggr_valid), 68'(0));
    chk($sformatf("v%0d_out_zero", idx), aggr_bus(), 68'(0));
    @(posedge clk); @(negedge clk);
    chk($sformatf("v%0d_slots", idx), 68'(slots_valid), 68'(v.slots));
  endtask
  initial begin
    rst = 1'b1; in_ready = 1'b0; clear = 1'b0; node_id = '0; adj_mask = '0;
    y4_relu_p3 = '0; y5_relu_p3 = '0; y6_relu_p3 = '0; y7_relu_p3 = '0;
    add(0, 4'b1111, 0, 100, 200, 300, 400, 100, 200, 300, 400, 4'b0001);
    add(0, 4'b0000, 0, 10, 20, 30, 40, 10, 20, 30, 40, 4'b0001);
    add(1, 4'b0000, 0, 1, 2, 3, 4, 1, 2, 3, 4, 4'b0011);
    add(2, 4'b0011, 0, 5, 5, 5, 5, 16, 27, 38, 49, 4'b0111);
    add(2, 4'b0001, 0, 5, 5, 5, 5, 15, 25, 35, 45, 4'b0111);
    add(0, 4'b0000, 0, 16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383, 4'b0111);
    add(1, 4'b0000, 0, 16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383, 4'b0111);
    add(2, 4'b0000, 0, 16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383, 4'b0111);
    add(3, 4'b1111, 0, 16383, 16383, 16383, 16383, 65532, 65532, 65532, 65532, 4'b1111);
    add(1, 4'b0010, 0, 7, 7, 7, 7, 7, 7, 7, 7, 4'b1111);
    add(0, 4'b0010, 0, 1, 1, 1, 1, 8, 8, 8, 8, 4'b1111);
    add(0, 4'b1110, 1, 2, 2, 2, 2, 32775, 32775, 32775, 32775, 4'b0000);
    add(3, 4'b1111, 0, 3, 4, 5, 6, 3, 4, 5, 6, 4'b1000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", 68'(aggr_valid), 68'(0));
    chk("reset_slots", 68'(slots_valid), 68'(0));
    chk("reset_aggr", aggr_bus(), 68'(0));
    foreach (vq[i]) run(vq[i], i);
    // strobe during P_MUL2 with another node must not relatch
    in_ready = 1'b1; node_id = 2'd2; adj_mask = 4'b1000;
    @(posedge clk); @(negedge clk);
    node_id = 2'd3; adj_mask = 4'b0000;
    @(posedge clk); @(negedge clk);
    in_ready = 1'b0;
    y4_relu_p3 = 15'd1; y5_relu_p3 = 15'd1; y6_relu_p3 = 15'd1; y7_relu_p3 = 15'd1;
    #1;
    chk("ignore_valid", 68'(aggr_valid), 68'(1));
    chk("ignore_aggr", aggr_bus(), {17'd4, 17'd5, 17'd6, 17'd7});
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("ignore_slots", 68'(slots_valid), 68'(4'b1100));
    // reset in P_MUL2 drops the pending node
    in_ready = 1'b1; node_id = 2'd0; adj_mask = 4'b1111;
    y4_relu_p3 = 15'd50; y5_relu_p3 = 15'd50; y6_relu_p3 = 15'd50; y7_relu_p3 = 15'd50;
    @(posedge clk); @(negedge clk);
    in_ready = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_mid_valid%0d", c), 68'(aggr_valid), 68'(0));
      @(posedge clk); @(negedge clk);
    end
    chk("rst_mid_slots", 68'(slots_valid), 68'(0));
    vq.delete();
    add(1, 4'b1111, 0, 9, 9, 9, 9, 9, 9, 9, 9, 4'b0010);
    run(vq[0], 99);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
